// File: rtl/axi_memory_master_write_burst.sv
// AXI4 write-burst master: one AW request, len W beats through a one-entry
// registered output stage, then one B response. Single clock, async reset.
module axi_memory_master_write_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // command
  input  logic                    start_write,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [31:0]             write_len,
  input  logic [2:0]              write_size,
  input  logic [1:0]              write_burst,
  // upstream data
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic                    wdata_in_valid,
  output logic                    wdata_in_ready,
  // AW channel
  output logic [3:0]              awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // W channel
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // B channel
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // status
  output logic                    busy,
  output logic                    write_done,
  output logic                    write_error
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [7:0]              r_awlen;
  logic [2:0]              r_awsize;
  logic [1:0]              r_awburst;
  logic                    r_awvalid;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_wlast;
  logic                    r_wvalid;
  logic                    r_write_done;
  logic                    r_write_error;
  logic [8:0]              r_len;     // 1..256
  logic [8:0]              r_loaded;  // beats pulled from upstream so far

  logic w_len_ok;
  logic w_in_ready;
  logic w_load;
  logic w_accept;

  assign w_len_ok   = (write_len != 32'd0) && (write_len <= 32'd256);
  // Output stage can take a new beat when empty or being drained this cycle.
  assign w_in_ready = (r_state == DATA) && (r_loaded < r_len) && (!r_wvalid || wready);
  assign w_load     = w_in_ready && wdata_in_valid;
  assign w_accept   = r_wvalid && wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_awaddr      <= '0;
      r_awlen       <= '0;
      r_awsize      <= '0;
      r_awburst     <= '0;
      r_awvalid     <= 1'b0;
      r_wdata       <= '0;
      r_wlast       <= 1'b0;
      r_wvalid      <= 1'b0;
      r_write_done  <= 1'b0;
      r_write_error <= 1'b0;
      r_len         <= '0;
      r_loaded      <= '0;
    end else begin
      r_write_done  <= 1'b0;
      r_write_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_write) begin
            if (w_len_ok) begin
              r_awaddr  <= write_addr;
              r_awlen   <= 8'(write_len - 32'd1);
              r_awsize  <= write_size;
              r_awburst <= write_burst;
              r_len     <= write_len[8:0];
              r_loaded  <= '0;
              r_awvalid <= 1'b1;
              r_state   <= ADDR;
            end else begin
              r_write_error <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (r_awvalid && awready) begin
            r_awvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_load) begin
            r_wdata  <= wdata_in;
            r_wvalid <= 1'b1;
            r_wlast  <= (r_loaded == r_len - 9'd1);
            r_loaded <= r_loaded + 9'd1;
          end else if (w_accept) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
          end
          // No load can coincide with the last accept: loaded == len by then.
          if (w_accept && r_wlast) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          if (bvalid) begin
            r_write_done  <= 1'b1;
            r_write_error <= (bresp != 2'b00);
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wdata_in_ready = w_in_ready;
  assign awid           = '0;
  assign awaddr         = r_awaddr;
  assign awlen          = r_awlen;
  assign awsize         = r_awsize;
  assign awburst        = r_awburst;
  assign awvalid        = r_awvalid;
  assign wdata          = r_wdata;
  assign wstrb          = {STRB_W{r_wvalid}};
  assign wlast          = r_wlast;
  assign wvalid         = r_wvalid;
  assign bready         = (r_state == RESP);
  assign busy           = (r_state != IDLE);
  assign write_done     = r_write_done;
  assign write_error    = r_write_error;

endmodule
